// File: rtl/flac_pkg.sv
// Shared FLAC decoder definitions: FSM states, size defaults and the
// fixed-predictor polynomial coefficients.
package flac_pkg;

  localparam int ORDER_MAX    = 4;
  localparam int SAMPLE_W_DEF = 16;
  localparam int ACC_W_DEF    = 21;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WARMUP = 2'd1,
    ST_RUN    = 2'd2
  } state_e;

  typedef logic signed [3:0] coef_t;

  // Row = order, column = weight applied to s1..s4 (binomial differences).
  localparam coef_t FIXED_COEF [0:ORDER_MAX][0:3] = '{
    '{4'sd0,  4'sd0,  4'sd0,  4'sd0},
    '{4'sd1,  4'sd0,  4'sd0,  4'sd0},
    '{4'sd2, -4'sd1,  4'sd0,  4'sd0},
    '{4'sd3, -4'sd3,  4'sd1,  4'sd0},
    '{4'sd4, -4'sd6,  4'sd4, -4'sd1}
  };

endpackage

// File: rtl/fixed_predictor_decoder_if.sv
// Handshake bundle between the residual decoder / control side and the
// fixed-predictor sample reconstructor.
interface fixed_predictor_decoder_if #(
  parameter int SAMPLE_W = 16
);
  logic                       iEnable;
  logic                       iStart;
  logic [2:0]                 iOrder;
  logic [15:0]                iNSamples;
  logic signed [SAMPLE_W-1:0] iWarmup;
  logic                       iWarmupValid;
  logic signed [SAMPLE_W-1:0] iResidual;
  logic                       iResidualValid;
  logic signed [SAMPLE_W-1:0] oSample;
  logic                       oValid;
  logic                       oDone;
  logic                       oBusy;
  logic                       oError;

  modport master (
    output iEnable, iStart, iOrder, iNSamples, iWarmup, iWarmupValid,
           iResidual, iResidualValid,
    input  oSample, oValid, oDone, oBusy, oError
  );

  modport slave (
    input  iEnable, iStart, iOrder, iNSamples, iWarmup, iWarmupValid,
           iResidual, iResidualValid,
    output oSample, oValid, oDone, oBusy, oError
  );
endinterface

// File: rtl/fixed_prediction.sv
// Combinational FLAC fixed-polynomial predictor: weighted sum of the last
// four samples for order 0..4; illegal orders predict zero.
module fixed_prediction
  import flac_pkg::*;
#(
  parameter int SAMPLE_W = SAMPLE_W_DEF,
  parameter int ACC_W    = ACC_W_DEF
) (
  input  logic signed [SAMPLE_W-1:0] s1,
  input  logic signed [SAMPLE_W-1:0] s2,
  input  logic signed [SAMPLE_W-1:0] s3,
  input  logic signed [SAMPLE_W-1:0] s4,
  input  logic [2:0]                 order,
  output logic signed [ACC_W-1:0]    pred
);

  function automatic logic signed [ACC_W-1:0] sext(input logic signed [SAMPLE_W-1:0] x);
    return {{(ACC_W-SAMPLE_W){x[SAMPLE_W-1]}}, x};
  endfunction

  function automatic logic signed [ACC_W-1:0] mulc(input logic signed [ACC_W-1:0] x,
                                                   input coef_t c);
    logic signed [ACC_W-1:0] cx;
    cx = {{(ACC_W-4){c[3]}}, c};
    return x * cx;
  endfunction

  always_comb begin
    pred = '0;
    if (order <= 3'(ORDER_MAX)) begin
      pred = mulc(sext(s1), FIXED_COEF[order][0])
           + mulc(sext(s2), FIXED_COEF[order][1])
           + mulc(sext(s3), FIXED_COEF[order][2])
           + mulc(sext(s4), FIXED_COEF[order][3]);
    end
  end

endmodule

// File: rtl/fixed_predictor_decoder.sv
// FLAC FIXED-subframe reconstructor: passes warm-up samples through, then adds
// each residual to the fixed prediction; one output per accepted input.
module fixed_predictor_decoder
  import flac_pkg::*;
#(
  parameter int SAMPLE_W = SAMPLE_W_DEF,
  parameter int ACC_W    = ACC_W_DEF
) (
  input logic                      iClock,
  input logic                      iReset,
  fixed_predictor_decoder_if.slave bus
);

  state_e                     state_q, state_d;
  logic [2:0]                 order_q, order_d;
  logic [15:0]                n_q, n_d;
  logic [15:0]                cnt_q, cnt_d;
  logic signed [SAMPLE_W-1:0] s1_q, s1_d, s2_q, s2_d, s3_q, s3_d, s4_q, s4_d;
  logic signed [SAMPLE_W-1:0] sample_q, sample_d;
  logic                       valid_q, valid_d, done_q, done_d;
  logic                       busy_q, busy_d, error_q, error_d;
  logic signed [ACC_W-1:0]    pred;
  logic signed [ACC_W-1:0]    sum;
  logic [15:0]                cnt_inc;

  fixed_prediction #(.SAMPLE_W(SAMPLE_W), .ACC_W(ACC_W)) u_pred (
    .s1(s1_q), .s2(s2_q), .s3(s3_q), .s4(s4_q), .order(order_q), .pred(pred)
  );

  function automatic logic signed [SAMPLE_W-1:0] wrap_sample(input logic signed [ACC_W-1:0] a);
    return a[SAMPLE_W-1:0];
  endfunction

  assign sum     = {{(ACC_W-SAMPLE_W){bus.iResidual[SAMPLE_W-1]}}, bus.iResidual} + pred;
  assign cnt_inc = cnt_q + 16'd1;

  always_comb begin
    state_d  = state_q;
    order_d  = order_q;
    n_d      = n_q;
    cnt_d    = cnt_q;
    s1_d     = s1_q;
    s2_d     = s2_q;
    s3_d     = s3_q;
    s4_d     = s4_q;
    sample_d = sample_q;
    valid_d  = 1'b0;
    done_d   = 1'b0;
    busy_d   = busy_q;
    error_d  = error_q;

    if (bus.iEnable) begin
      if (bus.iStart) begin
        order_d = bus.iOrder;
        n_d     = bus.iNSamples;
        if (bus.iOrder > 3'(ORDER_MAX) || bus.iNSamples == 16'd0 ||
            bus.iNSamples < 16'(bus.iOrder)) begin
          error_d = 1'b1;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          error_d = 1'b0;
          busy_d  = 1'b1;
          cnt_d   = '0;
          s1_d    = '0;
          s2_d    = '0;
          s3_d    = '0;
          s4_d    = '0;
          state_d = (bus.iOrder == 3'd0) ? ST_RUN : ST_WARMUP;
        end
      end else begin
        // Both WARMUP and RUN accept one sample, shift history and count it.
        unique case (state_q)
          ST_WARMUP: begin
            if (bus.iResidualValid) error_d = 1'b1;
            if (bus.iWarmupValid) begin
              sample_d = bus.iWarmup;
              valid_d  = 1'b1;
              s4_d = s3_q; s3_d = s2_q; s2_d = s1_q; s1_d = bus.iWarmup;
              cnt_d    = cnt_inc;
              if (cnt_inc == n_q) begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
              end else if (cnt_inc == 16'(order_q)) begin
                state_d = ST_RUN;
              end
            end
          end
          ST_RUN: begin
            if (bus.iWarmupValid) error_d = 1'b1;
            if (bus.iResidualValid) begin
              sample_d = wrap_sample(sum);
              valid_d  = 1'b1;
              s4_d = s3_q; s3_d = s2_q; s2_d = s1_q; s1_d = wrap_sample(sum);
              cnt_d    = cnt_inc;
              if (cnt_inc == n_q) begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge iClock) begin
    if (iReset) begin
      state_q  <= ST_IDLE;
      order_q  <= '0;
      n_q      <= '0;
      cnt_q    <= '0;
      s1_q     <= '0;
      s2_q     <= '0;
      s3_q     <= '0;
      s4_q     <= '0;
      sample_q <= '0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      order_q  <= order_d;
      n_q      <= n_d;
      cnt_q    <= cnt_d;
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      s3_q     <= s3_d;
      s4_q     <= s4_d;
      sample_q <= sample_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      error_q  <= error_d;
    end
  end

  assign bus.oSample = sample_q;
  assign bus.oValid  = valid_q;
  assign bus.oDone   = done_q;
  assign bus.oBusy   = busy_q;
  assign bus.oError  = error_q;

endmodule

// File: tb/tb_fixed_predictor_decoder.sv
// Directed bench for fixed_predictor_decoder with hand-computed expectations.
module tb_fixed_predictor_decoder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  fixed_predictor_decoder_if #(.SAMPLE_W(16)) bus ();

  fixed_predictor_decoder #(.SAMPLE_W(16), .ACC_W(21)) dut (
    .iClock(clk),
    .iReset(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic start(input logic [2:0] o, input logic [15:0] n);
    bus.iStart = 1'b1; bus.iOrder = o; bus.iNSamples = n;
    tick();
    bus.iStart = 1'b0;
  endtask

  task automatic warm(input logic signed [15:0] v);
    bus.iWarmup = v; bus.iWarmupValid = 1'b1;
    tick();
    bus.iWarmupValid = 1'b0;
  endtask

  task automatic res(input logic signed [15:0] v);
    bus.iResidual = v; bus.iResidualValid = 1'b1;
    tick();
    bus.iResidualValid = 1'b0;
  endtask

  // Check one output sample together with its done flag.
  task automatic out(input string tag, input logic signed [31:0] v, input logic d);
    chk({tag, "_valid"}, 32'(bus.oValid), 32'(1'b1));
    chk({tag, "_sample"}, bus.oSample, v);
    chk({tag, "_done"}, 32'(bus.oDone), 32'(d));
  endtask

  initial begin
    bus.iEnable = 1'b1; bus.iStart = 1'b0; bus.iOrder = '0; bus.iNSamples = '0;
    bus.iWarmup = '0; bus.iWarmupValid = 1'b0; bus.iResidual = '0; bus.iResidualValid = 1'b0;

    // Reset state
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("rst_valid", 32'(bus.oValid), 0);
    chk("rst_done",  32'(bus.oDone),  0);
    chk("rst_busy",  32'(bus.oBusy),  0);
    chk("rst_error", 32'(bus.oError), 0);
    chk("rst_sample", bus.oSample, 0);

    // Order 2: 10, 20, then residuals 0, 0, 1 -> 30, 40, 51
    start(3'd2, 16'd5);
    chk("o2_busy", 32'(bus.oBusy), 1);
    chk("o2_novalid", 32'(bus.oValid), 0);
    warm(16'sd10); out("o2_w0", 10, 1'b0);
    warm(16'sd20); out("o2_w1", 20, 1'b0);
    res(16'sd0);   out("o2_r0", 30, 1'b0);
    res(16'sd0);   out("o2_r1", 40, 1'b0);
    res(16'sd1);   out("o2_r2", 51, 1'b1);
    chk("o2_busy_end", 32'(bus.oBusy), 0);
    tick();
    chk("o2_idle_valid", 32'(bus.oValid), 0);
    chk("o2_idle_done", 32'(bus.oDone), 0);

    // Order 4, ascending then descending ramp
    start(3'd4, 16'd5);
    warm(16'sd1); warm(16'sd2); warm(16'sd3); warm(16'sd4);
    out("o4_w3", 4, 1'b0);
    res(16'sd0); out("o4_up", 5, 1'b1);
    start(3'd4, 16'd5);
    warm(-16'sd1); warm(-16'sd2); warm(-16'sd3); warm(-16'sd4);
    res(16'sd0); out("o4_dn", -5, 1'b1);

    // Order 0, back-to-back residuals
    start(3'd0, 16'd3);
    res(-16'sd5);    out("o0_a", -5, 1'b0);
    res(16'sd7);     out("o0_b", 7, 1'b0);
    res(16'sd32767); out("o0_c", 32767, 1'b1);
    tick();
    chk("o0_after", 32'(bus.oValid), 0);

    // Wrap on overflow: 32767 + 1 -> -32768
    start(3'd1, 16'd2);
    warm(16'sd32767);
    res(16'sd1); out("wrap", -32768, 1'b1);

    // Stall with iEnable low while a residual is presented
    start(3'd1, 16'd3);
    warm(16'sd100); out("st_w", 100, 1'b0);
    res(16'sd1);    out("st_r0", 101, 1'b0);
    bus.iEnable = 1'b0; bus.iResidual = 16'sd1; bus.iResidualValid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("st_hold_valid", 32'(bus.oValid), 0);
      chk("st_hold_busy", 32'(bus.oBusy), 1);
    end
    bus.iEnable = 1'b1;
    tick();
    bus.iResidualValid = 1'b0;
    out("st_r1", 102, 1'b1);

    // Illegal order
    start(3'd5, 16'd5);
    chk("bad_err", 32'(bus.oError), 1);
    chk("bad_done", 32'(bus.oDone), 1);
    chk("bad_busy", 32'(bus.oBusy), 0);
    tick();
    chk("bad_done_pulse", 32'(bus.oDone), 0);

    // Residual injected during WARMUP
    start(3'd2, 16'd4);
    chk("inj_err_clr", 32'(bus.oError), 0);
    warm(16'sd10); out("inj_w0", 10, 1'b0);
    res(16'sd99);
    chk("inj_drop", 32'(bus.oValid), 0);
    chk("inj_err", 32'(bus.oError), 1);
    warm(16'sd20); out("inj_w1", 20, 1'b0);
    res(16'sd5);   out("inj_r0", 35, 1'b0);
    res(16'sd0);   out("inj_r1", 50, 1'b1);
    chk("inj_err_sticky", 32'(bus.oError), 1);

    // Abort mid-RUN with a new start
    start(3'd1, 16'd5);
    warm(16'sd7);
    res(16'sd1); out("ab_r0", 8, 1'b0);
    start(3'd2, 16'd3);
    chk("ab_nodone", 32'(bus.oDone), 0);
    chk("ab_busy", 32'(bus.oBusy), 1);
    warm(16'sd3);
    warm(16'sd4);
    res(16'sd0); out("ab_r", 5, 1'b1);

    // Reset mid-block after raising error
    start(3'd1, 16'd5);
    warm(16'sd9);
    res(16'sd1); out("rs_r0", 10, 1'b0);
    warm(16'sd50);
    chk("rs_err", 32'(bus.oError), 1);
    rst = 1'b1; bus.iResidual = 16'sd1; bus.iResidualValid = 1'b1;
    tick();
    rst = 1'b0; bus.iResidualValid = 1'b0;
    chk("rs_valid", 32'(bus.oValid), 0);
    chk("rs_sample", bus.oSample, 0);
    chk("rs_busy", 32'(bus.oBusy), 0);
    chk("rs_error", 32'(bus.oError), 0);
    chk("rs_done", 32'(bus.oDone), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
